note_stream_scheduler: RTL and testbench
========================================

Name: note_stream_scheduler

Overview:
- Sequences the note-lane serial shift chain. Pattern bytes are buffered in a small FIFO and serialised MSB-first onto a single data line.
- Each bit is qualified by a one-cycle shift strobe, issued at a programmable step rate.
- FRAME_SYNC marks each completed byte, so the downstream byte tap can be sampled aligned.
- Sits between the song/pattern loader and the lane shift chain.

Parameters:
DIV_W, 16, width of step-period divider
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4 entries)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
DIV  in  DIV_W  step period minus 1, in CLK cycles; sampled at each divider reload
START  in  1  begin streaming (pulse)
STOP  in  1  finish current byte then halt (pulse)
PAT_VALID  in  1  pattern byte valid
PAT_DATA  in  8  pattern byte
PAT_READY  out  1  FIFO not full
SHIFT_EN  out  1  one-cycle strobe: DATA_OUT is a new bit
DATA_OUT  out  1  serial note bit, MSB first
FRAME_SYNC  out  1  coincident with SHIFT_EN for bit 0 (the 8th bit) of each byte
BUSY  out  1  state != IDLE
UNDERRUN  out  1  sticky: a rest byte was inserted
LEVEL  out  FIFO_AW+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high; it has priority over everything else.
- Reset values: state IDLE; FIFO empty; LEVEL=0; PAT_READY=1; SHIFT_EN=0; DATA_OUT=0; FRAME_SYNC=0; BUSY=0; UNDERRUN=0; divider=0; bit index=7.
- FIFO write side:
  - A write occurs when PAT_VALID && PAT_READY, in any state.
  - PAT_READY = (LEVEL != depth).
  - No bypass: a byte written in cycle T is poppable from T+1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on START. The divider loads DIV; bit index = 7. UNDERRUN clears.
  - RUN -> DRAIN on STOP.
  - DRAIN -> IDLE on the tick that emits bit 0.
  - START and STOP in the same cycle: STOP wins. From IDLE this means stay in IDLE.
  - START in RUN or DRAIN is ignored. STOP in IDLE or DRAIN is ignored.
- Divider and tick:
  - In RUN/DRAIN the divider decrements each cycle.
  - Tick = (divider == 0). On a tick the divider reloads the current DIV.
  - DIV=0 gives a tick every cycle. The first tick occurs DIV+1 cycles after START is sampled.
- Bit emission on a tick:
  - If bit index == 7: load the byte register. Pop the FIFO if LEVEL > 0; otherwise load rest byte 0x00 and set UNDERRUN.
  - Emit byte[index] (the just-loaded byte when index == 7).
  - Decrement the index, wrapping 0 -> 7.
- Output timing:
  - SHIFT_EN, DATA_OUT and FRAME_SYNC are registered and valid the cycle after the tick.
  - SHIFT_EN=0 on all other cycles. DATA_OUT holds its last value.
- LEVEL: registered. A simultaneous push and pop leaves it unchanged.
- Reset mid-byte: the partial byte is discarded, no FRAME_SYNC is issued, and the FIFO contents are lost.
- DIV changes take effect at the next reload only.

Optional Feature:
SCHED_LOOP_EN
- Defined: on an empty FIFO at a byte boundary, the previous byte is replayed instead of 0x00, and UNDERRUN is not set. If no byte has been loaded since START, 0x00 is used.
- Undefined: rest-byte and UNDERRUN behaviour as above.

Test Plan:
- Reset, then push 0xA5 and START with DIV=0: SHIFT_EN high 8 consecutive cycles starting 2 cycles after START; DATA_OUT sequence 1,0,1,0,0,1,0,1; FRAME_SYNC only on the 8th bit.
- DIV=3, push 0x81, START: SHIFT_EN pulses exactly every 4 cycles; BUSY=1 throughout.
- Push 4 bytes with no START: LEVEL=4, PAT_READY=0; a 5th PAT_VALID is not accepted. Then START with DIV=0: 32 bits out in order.
- FIFO empty at START with DIV=0: 8 zero bits, UNDERRUN=1. START in the next IDLE clears it.
  - With SCHED_LOOP_EN after 0x3C: repeats 0x3C, UNDERRUN stays 0.
- STOP after the 3rd bit of 0xF0 with a 2nd byte queued: the remaining 5 bits are emitted, then IDLE with LEVEL=1. START+STOP in the same cycle in IDLE: stays IDLE.
- RST asserted after the 4th bit: next cycle all outputs are at reset values and LEVEL=0. Then push 0x0F and START: a clean byte 0x0F is emitted.

Source files
------------

// File: rtl/note_stream_scheduler.sv
// Note-lane serialiser: buffers pattern bytes in a small FIFO and shifts them out MSB-first
// with one strobe per bit at a programmable step rate. Optional build macro: SCHED_LOOP_EN.
module note_stream_scheduler #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIV,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAT_VALID,
    input  logic [7:0]       PAT_DATA,
    output logic             PAT_READY,
    output logic             SHIFT_EN,
    output logic             DATA_OUT,
    output logic             FRAME_SYNC,
    output logic             BUSY,
    output logic             UNDERRUN,
    output logic [FIFO_AW:0] LEVEL,
    output logic [1:0]       DBG_STATE
);

    // PAT_VALID/PAT_READY: a byte transfers on every CLK edge where both are high,
    // in any state; PAT_READY depends only on registered occupancy.
    localparam int               DEPTH_N = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   divider;
    logic [2:0]         bit_idx;
    logic [7:0]         byte_reg;
    logic [7:0]         mem [DEPTH_N];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               shift_en_q;
    logic               data_out_q;
    logic               frame_sync_q;
    logic               underrun_q;

    logic       tick;
    logic       push;
    logic       pop;
    logic       byte_start;
    logic [7:0] next_byte;
    logic [7:0] emit_byte;

    assign tick       = (state != IDLE) && (divider == '0);
    assign push       = PAT_VALID && PAT_READY;
    assign byte_start = tick && (bit_idx == 3'd7);
    assign pop        = byte_start && (level != '0);

    // An empty FIFO at a byte boundary yields a rest byte, or a replay of the last byte when looping.
    always_comb begin
        next_byte = 8'h00;
        if (pop) begin
            next_byte = mem[rd_ptr];
        end else begin
`ifdef SCHED_LOOP_EN
            next_byte = byte_reg;
`else
            next_byte = 8'h00;
`endif
        end
    end

    assign emit_byte = (bit_idx == 3'd7) ? next_byte : byte_reg;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= PAT_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW + 1)'(1);
                2'b01:   level <= level - (FIFO_AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            divider      <= '0;
            bit_idx      <= 3'd7;
            byte_reg     <= 8'h00;
            shift_en_q   <= 1'b0;
            data_out_q   <= 1'b0;
            frame_sync_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            shift_en_q   <= 1'b0;
            frame_sync_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        state      <= RUN;
                        divider    <= DIV;
                        bit_idx    <= 3'd7;
                        byte_reg   <= 8'h00;
                        underrun_q <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (tick) begin
                        divider      <= DIV;
                        shift_en_q   <= 1'b1;
                        data_out_q   <= emit_byte[bit_idx];
                        frame_sync_q <= (bit_idx == 3'd0);
                        bit_idx      <= bit_idx - 3'd1;
                        if (bit_idx == 3'd7) begin
                            byte_reg <= next_byte;
                        end
`ifndef SCHED_LOOP_EN
                        if (byte_start && !pop) begin
                            underrun_q <= 1'b1;
                        end
`endif
                    end else begin
                        divider <= divider - DIV_W'(1);
                    end
                    if (state == DRAIN && tick && bit_idx == 3'd0) begin
                        state <= IDLE;
                    end else if (state == RUN && STOP) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PAT_READY  = (level != DEPTH);
    assign LEVEL      = level;
    assign BUSY       = (state != IDLE);
    assign DBG_STATE  = state;
    assign SHIFT_EN   = shift_en_q;
    assign DATA_OUT   = data_out_q;
    assign FRAME_SYNC = frame_sync_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_note_stream_scheduler.sv
// Bench for note_stream_scheduler: directed byte streams, scoreboard of {FRAME_SYNC, DATA_OUT} per strobe.
module tb_note_stream_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] div = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pat_valid = 1'b0;
  logic [7:0]  pat_data = '0;
  logic        pat_ready;
  logic        shift_en;
  logic        data_out;
  logic        frame_sync;
  logic        busy;
  logic        underrun;
  logic [2:0]  level;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s = 0;
  int busy_low = 0;
  logic [1:0] exp_q[$];
  int shift_cyc[$];

  note_stream_scheduler #(.DIV_W(16), .FIFO_AW(2)) dut (
    .CLK(clk), .RST(rst), .DIV(div), .START(start), .STOP(stop),
    .PAT_VALID(pat_valid), .PAT_DATA(pat_data), .PAT_READY(pat_ready),
    .SHIFT_EN(shift_en), .DATA_OUT(data_out), .FRAME_SYNC(frame_sync),
    .BUSY(busy), .UNDERRUN(underrun), .LEVEL(level), .DBG_STATE(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin
    if (shift_en) begin
      shift_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_shift actual={fs=%0b,d=%0b} expected=no strobe", frame_sync, data_out);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({frame_sync, data_out} !== e) begin
          failures++;
          $display("FAIL serial_bit actual={fs=%0b,d=%0b} expected={fs=%0b,d=%0b}",
                   frame_sync, data_out, e[1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    pat_valid = 1'b1;
    pat_data = b;
    step();
    pat_valid = 1'b0;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 0), b[i]});
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_shifts(input int n);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 2000) begin
      step();
      k++;
      if (shift_en) seen++;
    end
    check("wait_shifts_count", seen, n);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin
      step();
      k++;
    end
    check({name, "_idle"}, busy, 0);
    repeat (3) step();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    // T1: reset values, 0xA5 at DIV=0
    do_reset();
    check("rst_shift_en", shift_en, 0);
    check("rst_data_out", data_out, 0);
    check("rst_frame_sync", frame_sync, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_pat_ready", pat_ready, 1);
    check("rst_state", dbg_state, 0);
    div = 16'd0;
    push_byte(8'hA5);
    exp_byte(8'hA5);
    shift_cyc.delete();
    start_pulse();
    stop_pulse();
    wait_idle("a5");
    check("a5_count", shift_cyc.size(), 8);
    if (shift_cyc.size() == 8) begin
      check("a5_first_cycle", shift_cyc[0], s + 1);
      check("a5_last_cycle", shift_cyc[7], s + 8);
    end

    // T2: DIV=3, 0x81, strobe period 4, BUSY held
    div = 16'd3;
    push_byte(8'h81);
    exp_byte(8'h81);
    shift_cyc.delete();
    start_pulse();
    stop_pulse();
    busy_low = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!busy) busy_low++;
    end
    wait_idle("div3");
    check("div3_busy_low_cycles", busy_low, 0);
    check("div3_count", shift_cyc.size(), 8);
    if (shift_cyc.size() == 8) begin
      check("div3_first_cycle", shift_cyc[0], s + 4);
      for (int i = 1; i < 8; i++) check("div3_period", shift_cyc[i] - shift_cyc[i-1], 4);
    end

    // T3: fill FIFO, refuse 5th byte, stream 32 bits
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("full_level", level, 4);
    check("full_pat_ready", pat_ready, 0);
    push_byte(8'h55);
    check("full_level_after_5th", level, 4);
    exp_byte(8'h11);
    exp_byte(8'h22);
    exp_byte(8'h33);
    exp_byte(8'h44);
    div = 16'd0;
    shift_cyc.delete();
    start_pulse();
    wait_shifts(25);
    stop_pulse();
    wait_idle("fill4");
    check("fill4_count", shift_cyc.size(), 32);
    if (shift_cyc.size() == 32) check("fill4_span", shift_cyc[31] - shift_cyc[0], 31);
    check("fill4_level", level, 0);

    // T4: underrun from empty FIFO, cleared by next START
    exp_byte(8'h00);
    start_pulse();
    stop_pulse();
    wait_idle("empty");
`ifdef SCHED_LOOP_EN
    check("empty_underrun", underrun, 0);
`else
    check("empty_underrun", underrun, 1);
`endif
    exp_byte(8'h00);
    start_pulse();
    check("start_clears_underrun", underrun, 0);
    stop_pulse();
    wait_idle("empty2");

    // T4b: byte then empty FIFO: rest byte, or replay when looping
    push_byte(8'h3C);
    exp_byte(8'h3C);
`ifdef SCHED_LOOP_EN
    exp_byte(8'h3C);
`else
    exp_byte(8'h00);
`endif
    start_pulse();
    wait_shifts(8);
    stop_pulse();
    wait_idle("loop3c");
`ifdef SCHED_LOOP_EN
    check("loop3c_underrun", underrun, 0);
`else
    check("loop3c_underrun", underrun, 1);
`endif

    // T5: STOP after 3rd bit finishes the byte, 2nd byte stays queued
    push_byte(8'hF0);
    push_byte(8'h55);
    exp_byte(8'hF0);
    start_pulse();
    wait_shifts(3);
    stop_pulse();
    wait_idle("stop_f0");
    check("stop_f0_level", level, 1);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_state", dbg_state, 0);
    repeat (4) step();
    check("start_stop_level", level, 1);

    // T6: reset after 4th bit, FIFO contents lost, then a clean byte
    push_byte(8'h99);
    exp_byte(8'h55);
    start_pulse();
    wait_shifts(4);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("midrst_shift_en", shift_en, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_frame_sync", frame_sync, 0);
    check("midrst_busy", busy, 0);
    check("midrst_level", level, 0);
    check("midrst_pat_ready", pat_ready, 1);
    rst = 1'b0;
    step();
    push_byte(8'h0F);
    exp_byte(8'h0F);
    start_pulse();
    stop_pulse();
    wait_idle("clean0f");
    check("clean0f_underrun", underrun, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
